issue_queue: RTL and testbench

//  In-order dispatch FIFO between decode and the reservation stations. Buffers decoded task_t

---
 rtl/issue_queue_pkg.sv | 40 ++++
 rtl/iq_fifo.sv | 65 ++++++
 rtl/issue_queue.sv | 97 +++++++++
 tb/tb_issue_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared types for the decode -> issue -> reservation-station path:
// RS tags, the decoded task record and the issue-queue entry.
package issue_queue_pkg;

    localparam int RS_TAG_W = 4;

    // RS tag values index the rs_busy vector; INVALID means "no RS selected"
    typedef enum logic [RS_TAG_W-1:0] {
        RS_ALU0   = 4'd0,
        RS_ALU1   = 4'd1,
        RS_ALU2   = 4'd2,
        RS_MUL0   = 4'd3,
        RS_MUL1   = 4'd4,
        RS_LOAD0  = 4'd5,
        RS_LOAD1  = 4'd6,
        RS_STORE0 = 4'd7,
        INVALID   = 4'hF
    } RS_tag_type;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
        logic        reg_write;
    } task_t;

    // "task" is a keyword, so the task field is named tsk
    typedef struct packed {
        task_t      tsk;
        RS_tag_type rs;
    } iq_entry_t;

    // A dispatch renames rd only when it really writes a non-zero register
    function automatic logic renames(input task_t t);
        return t.reg_write && (t.rd != 5'd0);
    endfunction

endpackage

// File: rtl/iq_fifo.sv
// Circular buffer of issue-queue entries. Push is ignored when full, pop
// when empty, and flush clears occupancy and both pointers on the next edge.
module iq_fifo
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  iq_entry_t              i_data,
    input  logic                   i_pop,
    output iq_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    iq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full  && !i_flush;
    assign w_pop   = i_pop  && !o_empty && !i_flush;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Entry storage; slots outside the occupied window are never observed, so no reset
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue between decode and the reservation stations.
// The head entry is offered to its target RS whenever that RS is free;
// a busy head blocks everything behind it. Each dispatch also drives the
// map-table write renaming rd to the RS tag.
// Optional build macro ISSUE_Q_BYPASS_EN: an incoming task meeting an empty
// queue and a free RS dispatches in the same cycle without being stored.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_RS = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   flush,
    input  logic                   enq_valid,
    input  task_t                  enq_task,
    input  RS_tag_type             enq_rs,
    output logic                   enq_ready,
    input  logic [NUM_RS-1:0]      rs_busy,
    output task_t                  DISPATCH_TASK,
    output RS_tag_type             dest_RS,
    output logic                   map_we,
    output logic [4:0]             map_rd,
    output RS_tag_type             map_tag,
    output logic [$clog2(DEPTH):0] count
);

    iq_entry_t         w_enq_entry;
    iq_entry_t         w_head;
    iq_entry_t         w_sel;
    logic              w_full;
    logic              w_empty;
    logic [NUM_RS-1:0] w_head_sel;
    logic              w_head_busy;
    logic              w_head_fire;
    logic              w_byp_fire;
    logic              w_fire;
    logic              w_push;

    assign w_enq_entry = '{tsk: enq_task, rs: enq_rs};

    // One-hot of the head's RS; an out-of-range tag shifts out to all zeros
    assign w_head_sel  = NUM_RS'(1) << w_head.rs;
    assign w_head_busy = |(rs_busy & w_head_sel);
    assign w_head_fire = !w_empty && !w_head_busy && !flush;

`ifdef ISSUE_Q_BYPASS_EN
    logic [NUM_RS-1:0] w_enq_sel;
    logic              w_enq_busy;
    assign w_enq_sel  = NUM_RS'(1) << enq_rs;
    assign w_enq_busy = |(rs_busy & w_enq_sel);
    assign w_byp_fire = w_empty && enq_valid && !w_enq_busy && !flush;
`else
    assign w_byp_fire = 1'b0;
`endif

    // A bypassed task goes straight to the RS and must not also be stored
    assign w_push    = enq_valid && !w_full && !flush && !w_byp_fire;
    assign w_fire    = w_head_fire || w_byp_fire;
    assign w_sel     = w_byp_fire ? w_enq_entry : w_head;
    assign enq_ready = !w_full;

    iq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_enq_entry),
        .i_pop   (w_head_fire),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    // Dispatch bus and rename write; idle bus is zero with dest INVALID
    always_comb begin
        DISPATCH_TASK = '0;
        dest_RS       = INVALID;
        map_we        = 1'b0;
        map_rd        = w_sel.tsk.rd;
        map_tag       = w_sel.rs;
        if (w_fire) begin
            DISPATCH_TASK = w_sel.tsk;
            dest_RS       = w_sel.rs;
            map_we        = renames(w_sel.tsk);
        end
    end

    // Decode must never hand over a task without a target RS
    a_enq_rs_valid: assert property (@(posedge CLK) disable iff (!RST_N)
        (enq_valid && enq_ready && !flush) |-> (enq_rs != INVALID));

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: table-driven head-of-line / rename
// vectors plus hand-written fill, simultaneous, flush, bypass and reset
// sequences. A queue of expected entries is pushed on accepted enqueues and
// popped when a dispatch is expected.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH  = 8;
    localparam int NUM_RS = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    task_t       enq_task = '0;
    RS_tag_type  enq_rs = RS_ALU0;
    logic        enq_ready;
    logic [7:0]  rs_busy = 8'hFF;
    task_t       DISPATCH_TASK;
    RS_tag_type  dest_RS;
    logic        map_we;
    logic [4:0]  map_rd;
    RS_tag_type  map_tag;
    logic [3:0]  count;

    int n_tests = 0;
    int n_fail  = 0;
    iq_entry_t mq[$];

    issue_queue #(.DEPTH(DEPTH), .NUM_RS(NUM_RS)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .flush         (flush),
        .enq_valid     (enq_valid),
        .enq_task      (enq_task),
        .enq_rs        (enq_rs),
        .enq_ready     (enq_ready),
        .rs_busy       (rs_busy),
        .DISPATCH_TASK (DISPATCH_TASK),
        .dest_RS       (dest_RS),
        .map_we        (map_we),
        .map_rd        (map_rd),
        .map_tag       (map_tag),
        .count         (count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic iq_entry_t mk(input RS_tag_type rs, input int rd, input bit rw);
        iq_entry_t e;
        e.tsk.opcode    = 7'h33;
        e.tsk.rd        = 5'(rd);
        e.tsk.rs1       = 5'(rd + 1);
        e.tsk.rs2       = 5'(rd + 2);
        e.tsk.imm       = 16'(rd * 37 + 3);
        e.tsk.reg_write = rw;
        e.rs            = rs;
        return e;
    endfunction

    function automatic bit busy_of(input logic [7:0] b, input RS_tag_type t);
        logic [3:0] v;
        v = t;
        return (v < 4'd8) ? b[v[2:0]] : 1'b0;
    endfunction

    // One clock: drive at posedge+1, check combinational outputs at posedge+2,
    // then advance the expected-entry queue for the coming edge.
    task automatic cycle(input bit ev, input iq_entry_t e, input logic [7:0] busy, input bit fl);
        bit hf;
        bit bf;
        bit we;
        int sz;
        iq_entry_t x;
        @(posedge CLK);
        #1;
        enq_valid = ev;
        enq_task  = e.tsk;
        enq_rs    = e.rs;
        rs_busy   = busy;
        flush     = fl;
        #1;
        sz = mq.size();
        hf = 1'b0;
        bf = 1'b0;
        x  = e;
        if (sz > 0) begin
            x  = mq[0];
            hf = !busy_of(busy, mq[0].rs) && !fl;
        end
`ifdef ISSUE_Q_BYPASS_EN
        bf = (sz == 0) && ev && !busy_of(busy, e.rs) && !fl;
`endif
        chk("count", count, sz);
        chk("enq_ready", enq_ready, sz < DEPTH);
        if (hf || bf) begin
            we = x.tsk.reg_write && (x.tsk.rd != 5'd0);
            chk("dest_RS", dest_RS, x.rs);
            chk("dispatch_task", DISPATCH_TASK, x.tsk);
            chk("map_we", map_we, we);
            if (we) begin
                chk("map_rd", map_rd, x.tsk.rd);
                chk("map_tag", map_tag, x.rs);
            end
        end else begin
            chk("dest_RS_idle", dest_RS, INVALID);
            chk("map_we_idle", map_we, 1'b0);
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (hf)
                void'(mq.pop_front());
            if (ev && sz < DEPTH && !bf)
                mq.push_back(e);
        end
    endtask

    typedef struct {
        bit         ev;
        RS_tag_type rs;
        int         rd;
        bit         rw;
        logic [7:0] busy;
        int         cnt;
        RS_tag_type dst;
        bit         we;
        int         mrd;
    } vec_t;

    initial begin
        vec_t      tv[7];
        iq_entry_t idle;
        idle = mk(RS_ALU0, 0, 1'b0);

        // ALU0 busy holds the head; LOAD0 entry behind it waits, then ALU0, LOAD0, ALU1 in order
        tv[0] = '{1'b1, RS_ALU0,  5, 1'b1, 8'h01, 0, INVALID,  1'b0, 0};
        tv[1] = '{1'b1, RS_LOAD0, 0, 1'b1, 8'h01, 1, INVALID,  1'b0, 0};
        tv[2] = '{1'b1, RS_ALU1,  7, 1'b0, 8'h01, 2, INVALID,  1'b0, 0};
        tv[3] = '{1'b0, RS_ALU0,  0, 1'b0, 8'h00, 3, RS_ALU0,  1'b1, 5};
        tv[4] = '{1'b0, RS_ALU0,  0, 1'b0, 8'h00, 2, RS_LOAD0, 1'b0, 0};
        tv[5] = '{1'b0, RS_ALU0,  0, 1'b0, 8'h00, 1, RS_ALU1,  1'b0, 0};
        tv[6] = '{1'b0, RS_ALU0,  0, 1'b0, 8'h00, 0, INVALID,  1'b0, 0};

        // Reset state while RST_N is held low
        #3;
        chk("rst_count", count, 0);
        chk("rst_enq_ready", enq_ready, 1'b1);
        chk("rst_dest", dest_RS, INVALID);
        chk("rst_map_we", map_we, 1'b0);
        chk("rst_task", DISPATCH_TASK, 0);
        #9;
        RST_N = 1'b1;

        // Head-of-line blocking and rename vectors
        for (int i = 0; i < 7; i++) begin
            cycle(tv[i].ev, mk(tv[i].rs, tv[i].rd, tv[i].rw), tv[i].busy, 1'b0);
            chk("tv_count", count, tv[i].cnt);
            chk("tv_dest", dest_RS, tv[i].dst);
            chk("tv_map_we", map_we, tv[i].we);
            if (tv[i].we) begin
                chk("tv_map_rd", map_rd, tv[i].mrd);
                chk("tv_map_tag", map_tag, RS_ALU0);
            end
        end

        // Fill from a non-zero pointer so the write pointer wraps
        for (int i = 0; i < 8; i++)
            cycle(1'b1, mk(RS_tag_type'(i), i + 1, 1'b1), 8'hFF, 1'b0);
        cycle(1'b1, mk(RS_LOAD1, 20, 1'b1), 8'hFF, 1'b0);
        chk("full_count", count, 8);
        chk("full_enq_ready", enq_ready, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, idle, 8'h00, 1'b0);
            chk("fifo_order_rd", DISPATCH_TASK.rd, k + 1);
        end
        cycle(1'b0, idle, 8'h00, 1'b0);
        chk("drained_count", count, 0);

        // Simultaneous enqueue and dispatch with one entry held
        cycle(1'b1, mk(RS_MUL0, 9, 1'b1), 8'hFF, 1'b0);
        cycle(1'b1, mk(RS_MUL1, 10, 1'b1), 8'h00, 1'b0);
        chk("simul_rd", DISPATCH_TASK.rd, 9);
        cycle(1'b0, idle, 8'h00, 1'b0);
        chk("simul_count", count, 1);
        chk("simul_new_head", DISPATCH_TASK.rd, 10);
        cycle(1'b0, idle, 8'h00, 1'b0);

        // Flush four entries while a new task is offered and the head RS is free
        for (int i = 0; i < 4; i++)
            cycle(1'b1, mk(RS_tag_type'(i + 2), 11 + i, 1'b1), 8'hFF, 1'b0);
        cycle(1'b1, mk(RS_ALU2, 30, 1'b1), 8'h00, 1'b1);
        chk("flush_no_dispatch", dest_RS, INVALID);
        chk("flush_no_map_we", map_we, 1'b0);
        cycle(1'b0, idle, 8'h00, 1'b0);
        chk("flush_count", count, 0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, idle, 8'h00, 1'b0);

        // Empty queue, free RS: same-cycle dispatch only with bypass
        cycle(1'b1, mk(RS_LOAD0, 12, 1'b1), 8'h00, 1'b0);
`ifdef ISSUE_Q_BYPASS_EN
        chk("byp_same_cycle", dest_RS, RS_LOAD0);
`else
        chk("byp_same_cycle", dest_RS, INVALID);
`endif
        cycle(1'b0, idle, 8'h00, 1'b0);
`ifdef ISSUE_Q_BYPASS_EN
        chk("byp_next_count", count, 0);
        chk("byp_next_dest", dest_RS, INVALID);
`else
        chk("byp_next_count", count, 1);
        chk("byp_next_dest", dest_RS, RS_LOAD0);
`endif
        cycle(1'b0, idle, 8'h00, 1'b0);

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++)
            cycle(1'b1, mk(RS_ALU0, 21 + i, 1'b1), 8'hFF, 1'b0);
        @(posedge CLK);
        #1;
        enq_valid = 1'b0;
        rs_busy   = 8'h00;
        #1;
        chk("pre_rst_dest", dest_RS, RS_ALU0);
        chk("pre_rst_count", count, 3);
        #1;
        RST_N = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_enq_ready", enq_ready, 1'b1);
        chk("arst_dest", dest_RS, INVALID);
        chk("arst_map_we", map_we, 1'b0);
        mq.delete();
        #3;
        RST_N = 1'b1;
        cycle(1'b0, idle, 8'h00, 1'b0);
        cycle(1'b0, idle, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
